// File: rtl/csr_axil_slave_if.sv
// AXI4-Lite control-port bundle for the accelerator CSR block.
interface csr_axil_slave_if #(
  parameter int ADDR_W = 8
);
  logic              AWVALID;
  logic              AWREADY;
  logic [ADDR_W-1:0] AWADDR;
  logic [2:0]        AWPROT;
  logic [31:0]       WDATA;
  logic              WVALID;
  logic              WREADY;
  logic [3:0]        WSTRB;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY;
  logic              ARVALID;
  logic              ARREADY;
  logic [ADDR_W-1:0] ARADDR;
  logic [2:0]        ARPROT;
  logic [31:0]       RDATA;
  logic [1:0]        RRESP;
  logic              RVALID;
  logic              RREADY;

  modport slave (
    input  AWVALID, AWADDR, AWPROT, WDATA, WVALID, WSTRB, BREADY,
           ARVALID, ARADDR, ARPROT, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport master (
    output AWVALID, AWADDR, AWPROT, WDATA, WVALID, WSTRB, BREADY,
           ARVALID, ARADDR, ARPROT, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/csr_axil_slave.sv
// AXI4-Lite CSR file: flat config bus to the datapath, start pulse and busy/done status in CSR 0.
module csr_axil_slave #(
  parameter int LOG2_REG_NUM = 6,
  parameter int REG_NUM      = 1 << LOG2_REG_NUM,
  parameter int ADDR_W       = LOG2_REG_NUM + 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  csr_axil_slave_if.slave       s_axi,
  output logic [REG_NUM*32-1:0] cfg_regs,
  output logic                  start,
  input  logic                  done_i
);
  localparam int IDX_W = ADDR_W - 2;

  logic                     aw_held_q, aw_held_d;
  logic                     w_held_q, w_held_d;
  logic [IDX_W-1:0]         aw_idx_q, aw_idx_d;
  logic [31:0]              wdata_q, wdata_d;
  logic                     bvalid_q, bvalid_d;
  logic                     rvalid_q, rvalid_d;
  logic [31:0]              rdata_q, rdata_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     start_q, start_d;
  logic [REG_NUM-1:0][31:0] regs_q, regs_d;

  logic             awready, wready, arready;
  logic             aw_hs, w_hs, ar_hs, commit, launch;
  logic [IDX_W-1:0] ar_idx;
  logic [31:0]      rd_val;
  logic             unused_ok;

  assign awready = !aw_held_q && !bvalid_q;
  assign wready  = !w_held_q && !bvalid_q;
  assign arready = !rvalid_q;

  assign aw_hs  = s_axi.AWVALID && awready;
  assign w_hs   = s_axi.WVALID && wready;
  assign ar_hs  = s_axi.ARVALID && arready;
  assign commit = aw_held_q && w_held_q;
  assign launch = commit && (aw_idx_q == '0) && wdata_q[0];

  // Registers are sampled before this cycle's commit lands, so a colliding read sees the old value.
  assign ar_idx = s_axi.ARADDR[ADDR_W-1:2];
  assign rd_val = (ar_idx == '0) ? {30'b0, done_q, busy_q} : regs_q[ar_idx];

  always_comb begin
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    aw_idx_d  = aw_idx_q;
    wdata_d   = wdata_q;
    bvalid_d  = bvalid_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    busy_d    = busy_q;
    done_d    = done_q;
    regs_d    = regs_q;
    start_d   = launch;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_idx_d  = s_axi.AWADDR[ADDR_W-1:2];
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = s_axi.WDATA;
    end
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      if (aw_idx_q != '0) regs_d[aw_idx_q] = wdata_q;
    end else if (bvalid_q && s_axi.BREADY) begin
      bvalid_d = 1'b0;
    end

    // A launch in the same cycle as done_i overrides it.
    if (launch) begin
      busy_d = 1'b1;
      done_d = 1'b0;
    end else if (done_i) begin
      busy_d = 1'b0;
      done_d = 1'b1;
    end

    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_val;
    end else if (rvalid_q && s_axi.RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_idx_q  <= '0;
      wdata_q   <= '0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      start_q   <= 1'b0;
      regs_q    <= '0;
    end else begin
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      aw_idx_q  <= aw_idx_d;
      wdata_q   <= wdata_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      start_q   <= start_d;
      regs_q    <= regs_d;
    end
  end

  assign s_axi.AWREADY = awready;
  assign s_axi.WREADY  = wready;
  assign s_axi.ARREADY = arready;
  assign s_axi.BVALID  = bvalid_q;
  assign s_axi.BRESP   = 2'b00;
  assign s_axi.RVALID  = rvalid_q;
  assign s_axi.RDATA   = rdata_q;
  assign s_axi.RRESP   = 2'b00;

  assign cfg_regs = regs_q;
  assign start    = start_q;

  assign unused_ok = ^{s_axi.AWPROT, s_axi.ARPROT, s_axi.WSTRB,
                       s_axi.AWADDR[1:0], s_axi.ARADDR[1:0]};
endmodule
